// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared main memory.
// Port 0 is the I-cache miss port, port 1 the D-cache miss/write-through port.
module mem_arbiter #(
    parameter int READ_LAT = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              ack0,
    output logic [127:0]      rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [127:0]      rdata1,
    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [127:0]      mem_data_out,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a request, arbitrates round-robin
    // FILL  | mem_enable held high for READ_LAT cycles
    // CAPT  | line valid on mem_data_out, captured at closing edge
    // WRITE | single-cycle mem_write strobe
    // ACK   | one-cycle ack to the granted port
    typedef enum logic [2:0] {IDLE, FILL, CAPT, WRITE, ACK} state_t;

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                mem_enable_q, mem_enable_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [31:0]         mem_data_in_q, mem_data_in_d;
    logic [127:0]        rdata0_q, rdata0_d;
    logic [127:0]        rdata1_q, rdata1_d;
    logic                busy_q, busy_d;

    logic                sel_port;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        mem_enable_d  = mem_enable_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;

        // On a tie the port that was not served last wins.
        sel_port  = !(req0 && (!req1 || last_q));
        sel_we    = sel_port ? we1 : we0;
        sel_addr  = sel_port ? addr1 : addr0;
        sel_wdata = sel_port ? wdata1 : wdata0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d  = sel_port;
                    last_d = sel_port;
                    if (sel_we) begin
                        state_d       = WRITE;
                        mem_write_d   = 1'b1;
                        mem_address_d = sel_addr;
                        mem_data_in_d = sel_wdata;
                    end else begin
                        state_d       = FILL;
                        cnt_d         = CNT_W'(READ_LAT - 1);
                        mem_enable_d  = 1'b1;
                        mem_address_d = {sel_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            FILL: begin
                if (cnt_q == '0) begin
                    state_d      = CAPT;
                    mem_enable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPT: begin
                state_d = ACK;
                if (gnt_q) begin
                    rdata1_d = mem_data_out;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = mem_data_out;
                    ack0_d   = 1'b1;
                end
            end
            WRITE: begin
                state_d     = ACK;
                mem_write_d = 1'b0;
                ack0_d      = !gnt_q;
                ack1_d      = gnt_q;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            busy_q        <= busy_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_enable  = mem_enable_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of ordering, latency and memory contents.
module tb_mem_arbiter;

    localparam int READ_LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, we0, req1, we1;
    logic [31:0]  addr0, addr1, wdata0, wdata1;
    logic         ack0, ack1;
    logic [127:0] rdata0, rdata1;
    logic         mem_enable, mem_write;
    logic [31:0]  mem_address, mem_data_in;
    logic [127:0] mem_data_out;
    logic         busy;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.READ_LAT(READ_LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory device: line registered on each enable cycle, so it is valid
    // on the cycle after the last enable.
    logic [31:0]  mem [0:63];
    logic [5:0]   mb;
    assign mb = {mem_address[5:2], 2'b00};
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[5:0]] <= mem_data_in;
        if (mem_enable) mem_data_out <= {mem[mb + 6'd3], mem[mb + 6'd2], mem[mb + 6'd1], mem[mb]};
    end

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            assert (!(mem_enable && mem_write) && !(ack0 && ack1)) else begin
                fails++;
                $error("FAIL exclusive en=%0b wr=%0b ack0=%0b ack1=%0b required no overlap",
                       mem_enable, mem_write, ack0, ack1);
            end
        end
    end

    logic [31:0]  ref_mem [0:63];
    logic [127:0] exp_rd [0:1];
    int           cyc, port, tb_last, mode, first, p, explen;
    int           rw [0:1];
    int           ra [0:1];
    logic [31:0]  rd [0:1];

    function automatic logic [127:0] ref_line(input int a);
        int b;
        b = a & 60;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int c, output int pt);
        c  = 0;
        pt = -1;
        while (c < budget && pt < 0) begin
            tick;
            c++;
            if (ack0) pt = 0;
            else if (ack1) pt = 1;
        end
    endtask

    task automatic do_reset;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     <= (i < 2) ? 32'(i) : 32'(i + 23);
            ref_mem[i] = (i < 2) ? 32'(i) : 32'(i + 23);
        end

        // Reset state
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_memctl", {mem_enable, mem_write}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_data_in, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        rst = 1'b0;

        // Single port-0 read of addr 9
        req0 = 1; we0 = 0; addr0 = 9;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k <= 4) begin
                chk("rd_en", mem_enable, 1);
                chk("rd_addr", mem_address, 8);
            end
            if (k <= 5) chk("rd_busy", busy, 1);
            if (k == 5) chk("rd_capt", {mem_enable, ack0}, 0);
            if (k == 6) begin
                chk("rd_ack", {ack0, ack1}, 2'b10);
                chk("rd_data", rdata0, {32'd34, 32'd33, 32'd32, 32'd31});
            end
        end
        req0 = 0;
        tick;
        chk("rd_done", {ack0, busy}, 0);

        // Port-1 write then read of the same line
        req1 = 1; we1 = 1; addr1 = 5; wdata1 = 32'hDEAD;
        tick;
        chk("wr_strobe", {mem_write, mem_enable}, 2'b10);
        chk("wr_addr", mem_address, 5);
        chk("wr_data", mem_data_in, 32'hDEAD);
        tick;
        chk("wr_ack", {ack0, ack1}, 2'b01);
        chk("wr_rdata_kept", rdata1, 0);
        req1 = 0;
        ref_mem[5] = 32'hDEAD;
        tick;
        req1 = 1; we1 = 0; addr1 = 4;
        wait_ack(30, cyc, port);
        chk("wrrd_port", port, 1);
        chk("wrrd_lat", cyc, READ_LAT + 2);
        chk("wrrd_word", rdata1[63:32], 32'hDEAD);
        chk("wrrd_line", rdata1, {32'd30, 32'd29, 32'hDEAD, 32'd27});
        req1 = 0;
        tick;

        // Both held from reset: alternate 0,1,0
        do_reset;
        req0 = 1; we0 = 0; addr0 = 0;
        req1 = 1; we1 = 0; addr1 = 16;
        wait_ack(30, cyc, port);
        chk("rr1_port", port, 0);
        chk("rr1_lat", cyc, 6);
        chk("rr1_data", rdata0, {32'd26, 32'd25, 32'd1, 32'd0});
        wait_ack(30, cyc, port);
        chk("rr2_port", port, 1);
        chk("rr2_lat", cyc, 7);
        chk("rr2_data", rdata1, {32'd42, 32'd41, 32'd40, 32'd39});
        wait_ack(30, cyc, port);
        chk("rr3_port", port, 0);
        chk("rr3_lat", cyc, 7);
        req0 = 0; req1 = 0;
        tick;

        // Reset during FILL aborts without ack
        do_reset;
        req0 = 1; we0 = 0; addr0 = 12;
        tick;
        tick;
        chk("ab_fill", mem_enable, 1);
        rst = 1; req0 = 0;
        tick;
        chk("ab_state", {busy, mem_enable, ack0}, 0);
        chk("ab_rdata", rdata0, 0);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("ab_noack", {ack0, mem_enable}, 0);
        end
        req0 = 1;
        wait_ack(30, cyc, port);
        chk("ab_re_port", port, 0);
        chk("ab_re_lat", cyc, 6);
        chk("ab_re_data", rdata0, {32'd38, 32'd37, 32'd36, 32'd35});
        req0 = 0;
        tick;

        // Port 1 arrives during port-0 fill
        req0 = 1; we0 = 0; addr0 = 20;
        tick;
        tick;
        req1 = 1; we1 = 0; addr1 = 24;
        wait_ack(30, cyc, port);
        chk("late_p0", port, 0);
        chk("late_p0_lat", cyc, 4);
        req0 = 0;
        wait_ack(30, cyc, port);
        chk("late_p1", port, 1);
        chk("late_p1_lat", cyc, 7);
        chk("late_p1_data", rdata1, ref_line(24));
        req1 = 0;
        tick;

        // Top-of-range address aligns down
        req0 = 1; we0 = 0; addr0 = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("top_addr", mem_address, 32'hFFFF_FFFC);
        end
        wait_ack(30, cyc, port);
        chk("top_port", port, 0);
        chk("top_lat", cyc, 2);
        chk("top_data", rdata0, ref_line(60));
        req0 = 0;
        tick;

        // Randomized traffic
        do_reset;
        tb_last   = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(1, 3));
            for (int q = 0; q < 2; q++) begin
                rw[q] = int'($urandom_range(0, 1));
                ra[q] = int'($urandom_range(0, 63));
                rd[q] = $urandom;
            end
            req0 = mode[0]; we0 = rw[0][0]; addr0 = 32'(ra[0]); wdata0 = rd[0];
            req1 = mode[1]; we1 = rw[1][0]; addr1 = 32'(ra[1]); wdata1 = rd[1];
            if (mode == 3) first = (tb_last == 1) ? 0 : 1;
            else first = mode[0] ? 0 : 1;
            for (int n = 0; n < ((mode == 3) ? 2 : 1); n++) begin
                p      = (n == 0) ? first : 1 - first;
                explen = (rw[p] != 0 ? 2 : READ_LAT + 2) + n;
                wait_ack(30, cyc, port);
                chk("rnd_port", port, p);
                chk("rnd_lat", cyc, explen);
                if (rw[p] != 0) ref_mem[ra[p]] = rd[p];
                else exp_rd[p] = ref_line(ra[p]);
                chk("rnd_rdata0", rdata0, exp_rd[0]);
                chk("rnd_rdata1", rdata1, exp_rd[1]);
                if (p == 0) req0 = 0;
                else req1 = 0;
                tb_last = p;
            end
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
